ofmap_writer_param_3: RTL and testbench

OFMAP_WRITER_PARAM_3 -- requirements
Module: ofmap_writer_param_3

---
 rtl/ofmap_writer_param_3.sv | 102 ++++++++++
 tb/tb_ofmap_writer_param_3.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_writer_param_3.sv
// Output feature-map writer: takes result pixels from the conv/pool pipeline in raster
// order and emits one registered write per accepted pixel into the output memory.
module ofmap_writer_param_3 #(
  parameter int OUT_FEATURE_WIDTH = 4,
  parameter int NUM_OUT_FMAP      = 2,
  parameter int DATA_WIDTH        = 16,
  parameter int OUT_ADDR_WIDTH    = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      din_valid,
  input  logic [DATA_WIDTH-1:0]     din,
  output logic                      din_ready,
  output logic                      wea,
  output logic [OUT_ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      done
);

  localparam int CW = (OUT_FEATURE_WIDTH > 1) ? $clog2(OUT_FEATURE_WIDTH) : 1;
  localparam int FW = (NUM_OUT_FMAP > 1) ? $clog2(NUM_OUT_FMAP) : 1;
  localparam logic [CW-1:0] COL_MAX  = CW'(OUT_FEATURE_WIDTH - 1);
  localparam logic [FW-1:0] FMAP_MAX = FW'(NUM_OUT_FMAP - 1);
  localparam logic [OUT_ADDR_WIDTH-1:0] ROW_STRIDE = OUT_ADDR_WIDTH'(OUT_FEATURE_WIDTH);
  localparam logic [OUT_ADDR_WIDTH-1:0] MAP_STRIDE =
    OUT_ADDR_WIDTH'(OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                      state;
  logic [CW-1:0]               col;
  logic [CW-1:0]               row;
  logic [FW-1:0]               fmap;
  logic [OUT_ADDR_WIDTH-1:0]   pix_addr;
  logic                        accept;
  logic                        last_pix;

  assign din_ready = (state == WRITE) && enable;
  assign accept    = din_valid && din_ready;
  assign last_pix  = (col == COL_MAX) && (row == COL_MAX) && (fmap == FMAP_MAX);

  // Address arithmetic is done at the address width, so truncation wraps modulo 2^OUT_ADDR_WIDTH.
  assign pix_addr = OUT_ADDR_WIDTH'(fmap) * MAP_STRIDE
                  + OUT_ADDR_WIDTH'(row) * ROW_STRIDE
                  + OUT_ADDR_WIDTH'(col);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      fmap     <= '0;
      wea      <= 1'b0;
      addr_out <= '0;
      dout     <= '0;
      done     <= 1'b0;
    end else begin
      wea <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) state <= WRITE;
        end
        WRITE: begin
          if (accept) begin
            wea      <= 1'b1;
            addr_out <= pix_addr;
            dout     <= din;
            if (last_pix) begin
              col   <= '0;
              row   <= '0;
              fmap  <= '0;
              state <= DONE;
              done  <= 1'b1;
            end else if (col != COL_MAX) begin
              col <= col + 1'b1;
            end else begin
              col <= '0;
              if (row != COL_MAX) begin
                row <= row + 1'b1;
              end else begin
                row  <= '0;
                fmap <= fmap + 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (!enable) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_writer_param_3.sv
// Bench for ofmap_writer_param_3: directed vector table, hand-written corner sequences,
// and random traffic checked against a pixel-count reference model.
module tb_ofmap_writer_param_3;

  localparam int W     = 4;
  localparam int NMAP  = 2;
  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int TOTAL = NMAP * W * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          din_ready;
  logic          wea;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] dout;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = idle, 1 = writing, 2 = finished; k counts pixels accepted this run.
  int          m_phase = 0;
  int          m_k     = 0;
  logic        m_wea   = 1'b0;
  logic [31:0] m_addr  = 0;
  logic [31:0] m_dout  = 0;
  logic        m_done  = 1'b0;

  ofmap_writer_param_3 #(
    .OUT_FEATURE_WIDTH(W),
    .NUM_OUT_FMAP(NMAP),
    .DATA_WIDTH(DW),
    .OUT_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .din_valid(din_valid),
    .din(din),
    .din_ready(din_ready),
    .wea(wea),
    .addr_out(addr_out),
    .dout(dout),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    m_phase = 0;
    m_k     = 0;
    m_wea   = 1'b0;
    m_addr  = 0;
    m_dout  = 0;
    m_done  = 1'b0;
  endtask

  // One clock: drive inputs just after a falling edge, check ready, then check registered outputs.
  task automatic cycle(input logic en, input logic v, input logic [DW-1:0] d, output logic rdy);
    logic acc;
    enable    = en;
    din_valid = v;
    din       = d;
    #1;
    rdy = din_ready;
    chk("din_ready", {31'd0, din_ready}, {31'd0, (m_phase == 1) && en});
    acc   = v && (m_phase == 1) && en;
    m_wea = acc;
    case (m_phase)
      0: if (en) m_phase = 1;
      1: if (acc) begin
        m_addr = m_k % (1 << AW);
        m_dout = {16'd0, d};
        m_k++;
        if (m_k == TOTAL) begin
          m_k     = 0;
          m_phase = 2;
        end
      end
      2: if (!en) m_phase = 0;
      default: m_phase = 0;
    endcase
    m_done = (m_phase == 2);
    @(posedge clk);
    @(negedge clk);
    chk("wea",      {31'd0, wea},  {31'd0, m_wea});
    chk("addr_out", {26'd0, addr_out}, m_addr);
    chk("dout",     {16'd0, dout}, m_dout);
    chk("done",     {31'd0, done}, {31'd0, m_done});
  endtask

  typedef struct {
    logic          en;
    logic          v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          wea;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic rdy;
    int   wea_cnt;

    tbl[0] = '{1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'h0022, 1'b1, 1'b1, 6'd0, 16'h0022, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h0033, 1'b1, 1'b0, 6'd0, 16'h0022, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 16'h0044, 1'b1, 1'b1, 6'd1, 16'h0044, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h0055, 1'b0, 1'b0, 6'd1, 16'h0044, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16'h0066, 1'b1, 1'b1, 6'd2, 16'h0066, 1'b0};

    reset     = 1'b0;
    enable    = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    repeat (2) @(negedge clk);
    chk("rst_wea",   {31'd0, wea}, 32'd0);
    chk("rst_addr",  {26'd0, addr_out}, 32'd0);
    chk("rst_dout",  {16'd0, dout}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, din_ready}, 32'd0);
    reset = 1'b1;
    model_reset();

    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].en, tbl[i].v, tbl[i].d, rdy);
      chk("tbl_ready", {31'd0, rdy},  {31'd0, tbl[i].rdy});
      chk("tbl_wea",   {31'd0, wea},  {31'd0, tbl[i].wea});
      chk("tbl_addr",  {26'd0, addr_out}, {26'd0, tbl[i].addr});
      chk("tbl_dout",  {16'd0, dout}, {16'd0, tbl[i].dout});
      chk("tbl_done",  {31'd0, done}, {31'd0, tbl[i].done});
    end

    // Reset mid-frame after 10 accepts
    for (int i = 0; i < 40 && m_k < 10; i++) cycle(1'b1, 1'b1, DW'(16'h100 + i), rdy);
    chk("accepts_before_reset", m_k, 32'd10);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_wea",   {31'd0, wea}, 32'd0);
    chk("midrst_addr",  {26'd0, addr_out}, 32'd0);
    chk("midrst_dout",  {16'd0, dout}, 32'd0);
    chk("midrst_done",  {31'd0, done}, 32'd0);
    chk("midrst_ready", {31'd0, din_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Full run: din = 0..31 on consecutive cycles, dout must follow address
    cycle(1'b1, 1'b1, 16'hBEEF, rdy);
    wea_cnt = 0;
    for (int i = 0; i < TOTAL; i++) begin
      cycle(1'b1, 1'b1, DW'(i), rdy);
      if (wea) wea_cnt++;
      chk("run_addr", {26'd0, addr_out}, 32'(i));
      chk("run_dout", {16'd0, dout}, 32'(i));
      chk("run_done", {31'd0, done}, {31'd0, i == TOTAL - 1});
      if (i == 15) chk("map_wrap_last", {26'd0, addr_out}, 32'd15);
      if (i == 16) chk("map_wrap_next", {26'd0, addr_out}, 32'd16);
    end
    chk("run_wea_count", wea_cnt, 32'(TOTAL));

    // In DONE, valid data is ignored; then restart via IDLE
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 16'h7777, rdy);
      chk("done_no_wea", {31'd0, wea}, 32'd0);
      chk("done_hold",   {31'd0, done}, 32'd1);
    end
    cycle(1'b0, 1'b1, 16'h7777, rdy);
    chk("done_clear", {31'd0, done}, 32'd0);
    cycle(1'b1, 1'b1, 16'h7777, rdy);
    chk("idle_no_wea", {31'd0, wea}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, DW'(16'h200 + i), rdy);
      if (i == 0) begin
        chk("restart_addr", {26'd0, addr_out}, 32'd0);
        chk("restart_wea",  {31'd0, wea}, 32'd1);
        chk("restart_done", {31'd0, done}, 32'd0);
      end
    end

    // Pause for 3 cycles after 5 accepts, then resume at address 5
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 16'h3333, rdy);
      chk("pause_ready", {31'd0, rdy}, 32'd0);
      chk("pause_wea",   {31'd0, wea}, 32'd0);
    end
    cycle(1'b1, 1'b1, 16'h0205, rdy);
    chk("resume_addr", {26'd0, addr_out}, 32'd5);
    chk("resume_dout", {16'd0, dout}, 32'h205);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 8) != 0, ($urandom % 3) != 0, DW'($urandom), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
